// File: rtl/bitserial_nn_pkg.sv
// bitserial_nn_pkg: shared widths, address-width helper and loader state type
package bitserial_nn_pkg;
  // Address width with the same max(n,2) guard the engine uses on its ports.
  function automatic int aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int DATA_W   = 16;
  localparam int N_IN     = 128;
  localparam int N_HIDDEN = 64;
  localparam int N_LAYERS = 3;
  localparam int L_W = aw(N_LAYERS);
  localparam int H_W = aw(N_HIDDEN);
  localparam int I_W = aw(N_IN);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} ldr_state_t;
endpackage

// File: rtl/wmem_addr_gen.sv
// wmem_addr_gen: layer-major nested wrap counters for weight write addresses
module wmem_addr_gen
  import bitserial_nn_pkg::*;
#(
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64,
  parameter int N_LAYERS = 3
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      step,
  input  logic [aw(N_LAYERS)-1:0]   layer_init,
  input  logic [aw(N_LAYERS)-1:0]   layer_end,
  output logic [aw(N_LAYERS)-1:0]   l_cnt,
  output logic [aw(N_HIDDEN)-1:0]   h_cnt,
  output logic [aw(N_IN)-1:0]       i_cnt,
  output logic                      layer_last,
  output logic                      last_word
);
  localparam int LW = aw(N_LAYERS);
  localparam int HW = aw(N_HIDDEN);
  localparam int IW = aw(N_IN);
  logic [LW-1:0] l_end;
  logic          i_wrap, h_wrap;
  assign i_wrap     = i_cnt == IW'(N_IN - 1);
  assign h_wrap     = h_cnt == HW'(N_HIDDEN - 1);
  assign last_word  = i_wrap && h_wrap;
  assign layer_last = l_cnt == l_end;
  // Input count is innermost; its wrap carries into neuron, which carries into layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_cnt <= '0;
      h_cnt <= '0;
      i_cnt <= '0;
      l_end <= '0;
    end else if (load) begin
      l_cnt <= layer_init;
      l_end <= layer_end;
      h_cnt <= '0;
      i_cnt <= '0;
    end else if (step) begin
      i_cnt <= i_wrap ? '0 : i_cnt + 1'b1;
      if (i_wrap) h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (last_word) l_cnt <= l_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/wmem_stream_loader.sv
// wmem_stream_loader: AXI-Stream weight loader driving the engine weight write port
module wmem_stream_loader
  import bitserial_nn_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64,
  parameter int N_LAYERS = 3
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic                        cfg_all,
  input  logic [$clog2(N_LAYERS)-1:0] cfg_layer,
  input  logic                        nn_busy,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic                        w_wr_en,
  output logic [$clog2(N_LAYERS)-1:0] w_addr_l,
  output logic [aw(N_HIDDEN)-1:0]     w_addr_h,
  output logic [aw(N_IN)-1:0]         w_addr_i,
  output logic [DATA_W-1:0]           w_data,
  output logic                        loading,
  output logic                        load_done,
  output logic                        load_err
);
  localparam int LW = aw(N_LAYERS);
  ldr_state_t       state, state_n;
  logic             accept, cfg_bad, load, step, err_set, err_clr, done_n;
  logic             layer_last, last_word;
  logic [LW-1:0]    l_cnt;
  logic [aw(N_HIDDEN)-1:0] h_cnt;
  logic [aw(N_IN)-1:0]     i_cnt;
  assign s_axis_tready = (state == LOAD && !nn_busy) || state == FLUSH;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign loading       = state != IDLE;
  assign cfg_bad       = !cfg_all && (32'(cfg_layer) >= 32'(N_LAYERS));
  wmem_addr_gen #(.N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_LAYERS(N_LAYERS)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .layer_init (cfg_all ? '0 : LW'(cfg_layer)),
    .layer_end  (cfg_all ? LW'(N_LAYERS - 1) : LW'(cfg_layer)),
    .l_cnt      (l_cnt),
    .h_cnt      (h_cnt),
    .i_cnt      (i_cnt),
    .layer_last (layer_last),
    .last_word  (last_word)
  );
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // Next state plus framing decisions; every LOAD beat is written, even a misframed one.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    done_n  = 1'b0;
    if (state == IDLE && cfg_start) begin
      err_set = cfg_bad;
      err_clr = !cfg_bad;
      load    = !cfg_bad;
      state_n = cfg_bad ? IDLE : LOAD;
    end
    if (state == LOAD && accept) begin
      step = 1'b1;
      if (last_word && s_axis_tlast) begin
        done_n  = layer_last;
        state_n = layer_last ? IDLE : LOAD;
      end else if (last_word || s_axis_tlast) begin
        err_set = 1'b1;
        state_n = last_word ? FLUSH : IDLE;
      end
    end
    if (state == FLUSH && accept && s_axis_tlast) state_n = IDLE;
  end
  // Registered write port and status; done lands in the same cycle as the final write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_wr_en   <= 1'b0;
      w_addr_l  <= '0;
      w_addr_h  <= '0;
      w_addr_i  <= '0;
      w_data    <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      w_wr_en   <= step;
      load_done <= done_n;
      load_err  <= err_set || (load_err && !err_clr);
      if (step) begin
        w_addr_l <= l_cnt;
        w_addr_h <= h_cnt;
        w_addr_i <= i_cnt;
        w_data   <= s_axis_tdata;
      end
    end
  end
  // Writing into an engine that reports busy indicates a handshake problem upstream.
  assert property (@(posedge clk) disable iff (rst) !(w_wr_en && nn_busy))
    else $warning("wmem_stream_loader: w_wr_en asserted while nn_busy");
endmodule

// File: tb/tb_wmem_stream_loader.sv
// tb_wmem_stream_loader: scoreboard bench for the weight stream loader
module tb_wmem_stream_loader;
  logic        clk = 1'b0;
  logic        rst, cfg_start, cfg_all, nn_busy;
  logic [0:0]  cfg_layer, w_addr_l, w_addr_h;
  logic [1:0]  w_addr_i;
  logic [15:0] s_axis_tdata, w_data;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        w_wr_en, loading, load_done, load_err;
  typedef struct packed {
    logic [0:0]  l;
    logic [0:0]  h;
    logic [1:0]  i;
    logic [15:0] d;
    logic        done;
  } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0, done_cnt = 0;
  always #5 clk = ~clk;
  wmem_stream_loader #(.DATA_W(16), .N_IN(4), .N_HIDDEN(2), .N_LAYERS(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_all       (cfg_all),
    .cfg_layer     (cfg_layer),
    .nn_busy       (nn_busy),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .w_wr_en       (w_wr_en),
    .w_addr_l      (w_addr_l),
    .w_addr_h      (w_addr_h),
    .w_addr_i      (w_addr_i),
    .w_data        (w_data),
    .loading       (loading),
    .load_done     (load_done),
    .load_err      (load_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // Monitor: every write must match the oldest expected write, in order.
  always @(negedge clk) begin
    exp_t a, e;
    a = {w_addr_l, w_addr_h, w_addr_i, w_data, load_done};
    if (load_done) done_cnt++;
    if (w_wr_en) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got l=%0d h=%0d i=%0d d=%0h expected no write", a.l, a.h, a.i, a.d);
      end else begin
        e = q.pop_front();
        chk("write{l,h,i,d,done}", 32'(a), 32'(e));
      end
    end else if (load_done) begin
      checks++;
      $display("FAIL done_without_write: got load_done=1 expected 0");
    end
  end
  task automatic push(input int l, input int h, input int i, input int d, input bit done);
    exp_t e;
    e.l = 1'(l); e.h = 1'(h); e.i = 2'(i); e.d = 16'(d); e.done = done;
    q.push_back(e);
  endtask
  task automatic beat(input int d, input bit last);
    int n = 0;
    @(negedge clk);
    s_axis_tdata = 16'(d); s_axis_tlast = last; s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n == 50) begin
      checks++;
      $display("FAIL beat_timeout: got tready=0 expected 1");
    end else @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask
  task automatic start(input bit all, input bit layer);
    @(negedge clk);
    cfg_start = 1'b1; cfg_all = all; cfg_layer = layer;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("drain_pending", 32'(q.size()), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_all = 1'b0; cfg_layer = '0; nn_busy = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_en", w_wr_en, 0);
    chk("rst_loading", loading, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_addr_data", {w_addr_l, w_addr_h, w_addr_i, w_data}, 0);
    rst = 1'b0;
    // 1: all layers, 16 words
    start(1, 0);
    for (int k = 1; k <= 16; k++) begin
      push((k - 1) / 8, ((k - 1) / 4) % 2, (k - 1) % 4, k, k == 16);
      beat(k, k == 8 || k == 16);
    end
    drain();
    chk("t1_err", load_err, 0);
    chk("t1_loading", loading, 0);
    chk("t1_done_cnt", done_cnt, 1);
    // 2: single layer 1
    start(0, 1);
    for (int k = 1; k <= 8; k++) begin
      push(1, (k - 1) / 4, (k - 1) % 4, 16'h100 + k, k == 8);
      beat(16'h100 + k, k == 8);
    end
    drain();
    chk("t2_done_cnt", done_cnt, 2);
    chk("t2_loading", loading, 0);
    // 3: busy pause after beat 3
    start(0, 0);
    for (int k = 1; k <= 3; k++) begin
      push(0, 0, k - 1, 16'h200 + k, 1'b0);
      beat(16'h200 + k, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    nn_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_busy_tready", s_axis_tready, 0);
      chk("t3_busy_wr_en", w_wr_en, 0);
      @(negedge clk);
    end
    nn_busy = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      push(0, (k - 1) / 4, (k - 1) % 4, 16'h200 + k, k == 8);
      beat(16'h200 + k, k == 8);
    end
    drain();
    chk("t3_done_cnt", done_cnt, 3);
    // 4: early tlast on word 5
    start(0, 0);
    for (int k = 1; k <= 5; k++) begin
      push(0, (k - 1) / 4, (k - 1) % 4, 16'h300 + k, 1'b0);
      beat(16'h300 + k, k == 5);
    end
    drain();
    chk("t4_err", load_err, 1);
    chk("t4_loading", loading, 0);
    chk("t4_done_cnt", done_cnt, 3);
    // 5: missing tlast on word 8, flush to word 10
    start(0, 0);
    chk("t5_err_cleared", load_err, 0);
    for (int k = 1; k <= 8; k++) begin
      push(0, (k - 1) / 4, (k - 1) % 4, 16'h400 + k, 1'b0);
      beat(16'h400 + k, 1'b0);
    end
    drain();
    chk("t5_flush_loading", loading, 1);
    chk("t5_flush_err", load_err, 1);
    chk("t5_flush_tready", s_axis_tready, 1);
    beat(16'h409, 1'b0);
    beat(16'h40a, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("t5_loading", loading, 0);
    chk("t5_err", load_err, 1);
    chk("t5_done_cnt", done_cnt, 3);
    // 6: reset mid-load, then fresh load from (0,0,0)
    start(1, 0);
    for (int k = 1; k <= 3; k++) begin
      push(0, 0, k - 1, 16'h500 + k, 1'b0);
      beat(16'h500 + k, 1'b0);
    end
    drain();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_loading", loading, 0);
    chk("t6_rst_tready", s_axis_tready, 0);
    chk("t6_rst_addr_i", w_addr_i, 0);
    chk("t6_rst_data", w_data, 0);
    @(negedge clk);
    rst = 1'b0;
    start(0, 0);
    for (int k = 1; k <= 8; k++) begin
      push(0, (k - 1) / 4, (k - 1) % 4, 16'h600 + k, k == 8);
      beat(16'h600 + k, k == 8);
    end
    drain();
    chk("t6_done_cnt", done_cnt, 4);
    chk("t6_err", load_err, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
